// File: rtl/clint_regs.sv
// CLINT register block: per-hart msip and mtimecmp, shared mtime counter driven by an
// asynchronous RTC input, and the registered timer / software interrupt lines.
module clint_regs #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned NR_CORES       = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   address_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  input  logic                        rtc_i,
  output logic [NR_CORES-1:0]         timer_irq_o,
  output logic [NR_CORES-1:0]         ipi_o
);

  localparam logic [12:0] MtimecmpWord = 13'h0800;
  localparam logic [12:0] MtimeWord    = 13'h17ff;

  logic [12:0] word;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic        unused_addr;

  logic                s0_q, s1_q, rtc_q;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q [NR_CORES];
  logic [63:0]         mtimecmp_d [NR_CORES];
  logic [NR_CORES-1:0] msip_q, msip_d;
  logic [NR_CORES-1:0] timer_irq_q, timer_irq_d;
  logic [NR_CORES-1:0] ipi_q, ipi_d;
  logic [63:0]         rdata;

  assign word        = address_i[15:3];
  assign wr_en       = en_i & we_i;
  assign rd_en       = en_i & ~we_i;
  assign tick        = s1_q & ~rtc_q;
  assign unused_addr = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    mtime_d    = mtime_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;

    // A software write to mtime takes precedence over the RTC increment.
    if (wr_en && (word == MtimeWord)) begin
      mtime_d = merge_bytes(mtime_q, wdata_i, be_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    for (int unsigned h = 0; h < NR_CORES; h++) begin
      if (wr_en && (word == 13'(h >> 1))) begin
        if ((h % 2) == 0) begin
          if (be_i[0]) msip_d[h] = wdata_i[0];
        end else begin
          if (be_i[4]) msip_d[h] = wdata_i[32];
        end
      end
      if (wr_en && (word == MtimecmpWord + 13'(h))) begin
        mtimecmp_d[h] = merge_bytes(mtimecmp_q[h], wdata_i, be_i);
      end
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < NR_CORES; h++) begin
      timer_irq_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
    ipi_d = msip_q;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      for (int unsigned h = 0; h < NR_CORES; h++) begin
        if (word == 13'(h >> 1)) begin
          if ((h % 2) == 0) rdata[0] = msip_q[h];
          else              rdata[32] = msip_q[h];
        end
        if (word == MtimecmpWord + 13'(h)) rdata = mtimecmp_q[h];
      end
      if (word == MtimeWord) rdata = mtime_q;
    end
  end

  assign rdata_o     = rdata;
  assign timer_irq_o = timer_irq_q;
  assign ipi_o       = ipi_q;

  // Two-flop synchronizer plus an edge-detect stage for the RTC input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
      rtc_q <= 1'b0;
    end else begin
      s0_q  <= rtc_i;
      s1_q  <= s0_q;
      rtc_q <= s1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '{default: '1};
      msip_q      <= '0;
      timer_irq_q <= '0;
      ipi_q       <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      ipi_q       <= ipi_d;
    end
  end

endmodule

// File: tb/tb_clint_regs.sv
// Self-checking bench for clint_regs: directed scenarios plus randomized traffic compared
// every cycle against a behavioural register-map model.
module tb_clint_regs;
  localparam int unsigned NC = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic          we_i = 1'b0;
  logic          rtc_i = 1'b0;
  logic [63:0]   address_i = '0;
  logic [7:0]    be_i = '0;
  logic [63:0]   wdata_i = '0;
  logic [63:0]   rdata_o;
  logic [NC-1:0] timer_irq_o;
  logic [NC-1:0] ipi_o;

  int n_checks = 0;
  int n_fail   = 0;

  clint_regs #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .NR_CORES      (NC)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .we_i       (we_i),
    .address_i  (address_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .rtc_i      (rtc_i),
    .timer_irq_o(timer_irq_o),
    .ipi_o      (ipi_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model state
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NC];
  logic [NC-1:0] m_msip, m_irq, m_ipi;
  logic          r1, r2, r3;  // rtc_i sampled one, two, three edges ago
  logic          m_tick, m_mtime_wr;

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] d,
                                         input logic [7:0] be);
    for (int i = 0; i < 8; i++) if (be[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    int unsigned off;
    logic [63:0] r;
    off = int'(a[15:0]) & 32'hfff8;
    r = '0;
    if (off / 4 < NC) begin
      r[0] = m_msip[off/4];
      if (off / 4 + 1 < NC) r[32] = m_msip[off/4+1];
    end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NC) begin
      r = m_cmp[(off - 32'h4000) / 8];
    end else if (off == 32'hbff8) begin
      r = m_mtime;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mtime = '0;
    for (int h = 0; h < NC; h++) m_cmp[h] = '1;
    m_msip = '0;
    m_irq  = '0;
    m_ipi  = '0;
    r1 = 1'b0;
    r2 = 1'b0;
    r3 = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        model_reset();
      end else begin
        // mtime steps two edges after rtc_i is first seen high at an edge.
        m_tick = r2 && !r3;
        for (int h = 0; h < NC; h++) m_irq[h] = (m_mtime >= m_cmp[h]);
        m_ipi = m_msip;
        m_mtime_wr = 1'b0;
        if (en_i && we_i) begin
          int unsigned off;
          off = int'(address_i[15:0]) & 32'hfff8;
          if (off / 4 < NC) begin
            if (be_i[0]) m_msip[off/4] = wdata_i[0];
            if (off / 4 + 1 < NC && be_i[4]) m_msip[off/4+1] = wdata_i[32];
          end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NC) begin
            m_cmp[(off - 32'h4000) / 8] = bmerge(m_cmp[(off - 32'h4000) / 8], wdata_i, be_i);
          end else if (off == 32'hbff8) begin
            m_mtime = bmerge(m_mtime, wdata_i, be_i);
            m_mtime_wr = 1'b1;
          end
        end
        if (m_tick && !m_mtime_wr) m_mtime = m_mtime + 64'd1;
        r3 = r2;
        r2 = r1;
        r1 = rtc_i;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        chk("rdata_model", rdata_o, (en_i && !we_i) ? m_read(address_i) : 64'd0);
        chk("irq_model", 64'(timer_irq_o), 64'(m_irq));
        chk("ipi_model", 64'(ipi_o), 64'(m_ipi));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    en_i = 1'b1;
    we_i = 1'b1;
    address_i = a;
    wdata_i = d;
    be_i = be;
    cyc();
    en_i = 1'b0;
    we_i = 1'b0;
  endtask

  task automatic rd(input string name, input logic [63:0] a, input logic [63:0] exp);
    en_i = 1'b1;
    we_i = 1'b0;
    address_i = a;
    #1;
    chk(name, rdata_o, exp);
    en_i = 1'b0;
  endtask

  task automatic rtc_pulse();
    rtc_i = 1'b1;
    repeat (6) cyc();
    rtc_i = 1'b0;
    repeat (6) cyc();
  endtask

  initial begin
    int rtc_cnt;
    logic [15:0] bases [8];

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cyc();

    rd("reset_mtime", 64'hbff8, 64'd0);
    rd("reset_mtimecmp", 64'h4000, 64'hffff_ffff_ffff_ffff);
    chk("reset_irq", 64'(timer_irq_o), 64'd0);
    chk("reset_ipi", 64'(ipi_o), 64'd0);

    wr(64'h0, 64'h0000_0001_0000_0001, 8'h11);
    chk("ipi_latency", 64'(ipi_o), 64'd0);
    cyc();
    chk("ipi_set", 64'(ipi_o), 64'h3);
    rd("msip_read", 64'h0, 64'h0000_0001_0000_0001);
    wr(64'h0, 64'h0, 8'h01);
    cyc();
    chk("ipi_clear0", 64'(ipi_o), 64'h2);

    wr(64'h4000, 64'd5, 8'hff);
    wr(64'hbff8, 64'd3, 8'hff);
    rtc_pulse();
    rd("mtime_one_tick", 64'hbff8, 64'd4);
    rtc_i = 1'b1;
    cyc();
    chk("irq_k", 64'(timer_irq_o[0]), 64'd0);
    cyc();
    cyc();
    chk("irq_k2", 64'(timer_irq_o[0]), 64'd0);
    rd("mtime_two_ticks", 64'hbff8, 64'd5);
    cyc();
    chk("irq_k3", 64'(timer_irq_o[0]), 64'd1);
    repeat (5) cyc();
    rtc_i = 1'b0;
    repeat (6) cyc();
    rd("mtime_held_high", 64'hbff8, 64'd5);
    wr(64'h4000, 64'd6, 8'hff);
    chk("irq_still_set", 64'(timer_irq_o[0]), 64'd1);
    cyc();
    chk("irq_dropped", 64'(timer_irq_o[0]), 64'd0);

    wr(64'h4008, 64'h1122_3344_5566_7788, 8'h0f);
    rd("byte_enable", 64'h4008, 64'hffff_ffff_5566_7788);

    wr(64'hbff8, 64'hffff_ffff_ffff_ffff, 8'hff);
    rtc_pulse();
    rd("mtime_wrap", 64'hbff8, 64'd0);
    rtc_i = 1'b1;
    cyc();
    cyc();
    wr(64'hbff8, 64'h100, 8'hff);
    rd("write_beats_tick", 64'hbff8, 64'h100);
    rtc_i = 1'b0;
    repeat (6) cyc();
    rd("no_late_tick", 64'hbff8, 64'h100);

    wr(64'h8000, 64'hdead_beef_cafe_f00d, 8'hff);
    rd("unmapped", 64'h8000, 64'd0);
    rd("unmapped_cmp0", 64'h4000, 64'd6);
    rd("unmapped_mtime", 64'hbff8, 64'h100);
    rd("hart2_absent", 64'h4010, 64'd0);

    // Asynchronous reset with a tick in flight
    rtc_i = 1'b1;
    cyc();
    #2 rst_ni = 1'b0;
    rtc_i = 1'b0;
    #1;
    chk("async_rst_irq", 64'(timer_irq_o), 64'd0);
    chk("async_rst_ipi", 64'(ipi_o), 64'd0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    repeat (4) cyc();
    rd("rst_mtime", 64'hbff8, 64'd0);
    rd("rst_cmp1", 64'h4008, 64'hffff_ffff_ffff_ffff);
    rd("rst_msip", 64'h0, 64'd0);

    bases = '{16'h0000, 16'h0008, 16'h4000, 16'h4008, 16'h4010, 16'hbff8, 16'h8000, 16'h0};
    rtc_cnt = 4;
    for (int i = 0; i < 3000; i++) begin
      if (rtc_cnt == 0) begin
        rtc_i = ~rtc_i;
        rtc_cnt = $urandom_range(4, 12);
      end else begin
        rtc_cnt--;
      end
      bases[7] = 16'($urandom);
      en_i = ($urandom_range(0, 3) != 0);
      we_i = ($urandom_range(0, 2) == 0);
      address_i = {$urandom, 16'($urandom), bases[$urandom_range(0, 7)] | 16'($urandom_range(0, 7))};
      wdata_i = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 60));
      be_i = ($urandom_range(0, 1) == 0) ? 8'hff : 8'($urandom);
      cyc();
    end
    en_i = 1'b0;
    we_i = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
